uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/sys_ctrl_pkg.sv | 17 +
 rtl/uart_cmd_decoder.sv | 136 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system-control path: UART command codes and the
// command decoder state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR_CODE = 8'hAA;
  localparam logic [7:0] CMD_RD_CODE = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_SEND = 3'd5
  } state_e;

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received byte sequences into register-file
// write/read strobes and forwards read responses to the TX FIFO.
module uart_cmd_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(CMD_WR_CODE),
  parameter logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(CMD_RD_CODE)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  input  logic                  FIFO_FULL,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    rx_acc;
  logic                    rx_bad;

  assign rx_acc = RX_D_VLD & ~PAR_ERR & ~STP_ERR;
  assign rx_bad = RX_D_VLD & (PAR_ERR | STP_ERR);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;

    // A corrupted byte aborts whatever is in flight, including a pending read.
    if (rx_bad) begin
      cmd_err_d = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_acc) begin
            if (RX_P_DATA == CMD_WR)      state_d   = ST_WR_ADDR;
            else if (RX_P_DATA == CMD_RD) state_d   = ST_RD_ADDR;
            else                          cmd_err_d = 1'b1;
          end
        end
        ST_WR_ADDR: begin
          if (rx_acc) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (rx_acc) begin
            wr_en_d   = 1'b1;
            wr_data_d = RX_P_DATA;
            state_d   = ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (rx_acc) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            state_d = ST_RD_WAIT;
          end
        end
        // While a read is outstanding, new bytes are rejected but the read goes on.
        ST_RD_WAIT: begin
          cmd_err_d = rx_acc;
          if (RF_RdData_VLD) begin
            tx_data_d = RF_RdData;
            state_d   = ST_RD_SEND;
          end
        end
        ST_RD_SEND: begin
          cmd_err_d = rx_acc;
          if (!FIFO_FULL) begin
            tx_vld_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign RF_Address = addr_q;
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_WrData  = wr_data_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a command-level byte-stream model predicts every
// strobe cycle by cycle, plus literal checks on the directed scenarios.
module tb_uart_cmd_decoder;

  logic       CLK, RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD, PAR_ERR, STP_ERR;
  logic [7:0] RF_RdData;
  logic       RF_RdData_VLD, FIFO_FULL;
  logic [3:0] RF_Address;
  logic       RF_WrEn, RF_RdEn;
  logic [7:0] RF_WrData, TX_P_DATA;
  logic       TX_D_VLD, CMD_ERR;

  uart_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CMD_WR(8'hAA), .CMD_RD(8'hBB)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .RF_RdData(RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD), .FIFO_FULL(FIFO_FULL),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: accepted bytes collect into a buffer that is
  // interpreted as a whole command; one read response may be outstanding.
  logic [7:0] m_buf[$];
  bit         m_rd_busy, m_have;
  logic [7:0] m_rdata;
  bit         e_wr, e_rd, e_tx, e_err;
  logic [3:0] e_addr;
  logic [7:0] e_wdata, e_tdata;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_buf.delete();
      m_rd_busy = 0; m_have = 0; m_rdata = 0;
      e_wr = 0; e_rd = 0; e_tx = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_tdata = 0;
    end else begin
      e_wr = 0; e_rd = 0; e_tx = 0; e_err = 0;
      if (RX_D_VLD && (PAR_ERR || STP_ERR)) begin
        e_err = 1;
        m_buf.delete();
        m_rd_busy = 0; m_have = 0;
      end else if (m_rd_busy) begin
        if (RX_D_VLD) e_err = 1;
        if (!m_have) begin
          if (RF_RdData_VLD) begin m_have = 1; m_rdata = RF_RdData; end
        end else if (!FIFO_FULL) begin
          e_tx = 1; e_tdata = m_rdata;
          m_rd_busy = 0; m_have = 0;
        end
      end else if (RX_D_VLD) begin
        m_buf.push_back(RX_P_DATA);
        if (m_buf[0] != 8'hAA && m_buf[0] != 8'hBB) begin
          e_err = 1;
          m_buf.delete();
        end else if (m_buf[0] == 8'hAA && m_buf.size() == 3) begin
          e_wr = 1; e_addr = m_buf[1][3:0]; e_wdata = m_buf[2];
          m_buf.delete();
        end else if (m_buf[0] == 8'hBB && m_buf.size() == 2) begin
          e_rd = 1; e_addr = m_buf[1][3:0];
          m_rd_busy = 1;
          m_buf.delete();
        end
      end
    end
  end

  int         n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
  logic [3:0] last_wr_addr = 0, last_rd_addr = 0;
  logic [7:0] last_wr_data = 0, last_tx = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      chk("wr_en", RF_WrEn, e_wr);
      chk("rd_en", RF_RdEn, e_rd);
      chk("tx_vld", TX_D_VLD, e_tx);
      chk("cmd_err", CMD_ERR, e_err);
      chk("wr_rd_excl", RF_WrEn & RF_RdEn, 0);
      if (e_wr) begin
        chk("wr_addr", RF_Address, e_addr);
        chk("wr_data", RF_WrData, e_wdata);
      end
      if (e_rd) chk("rd_addr", RF_Address, e_addr);
      if (e_tx) chk("tx_data", TX_P_DATA, e_tdata);
      if (RF_WrEn)  begin n_wr++; last_wr_addr = RF_Address; last_wr_data = RF_WrData; end
      if (RF_RdEn)  begin n_rd++; last_rd_addr = RF_Address; end
      if (TX_D_VLD) begin n_tx++; last_tx = TX_P_DATA; end
      if (CMD_ERR)  n_err++;
    end
  end

  task automatic send(input logic [7:0] b, input logic p, input logic s);
    @(negedge CLK);
    RX_P_DATA = b; RX_D_VLD = 1; PAR_ERR = p; STP_ERR = s;
    @(negedge CLK);
    RX_D_VLD = 0; PAR_ERR = 0; STP_ERR = 0;
  endtask

  task automatic rf_resp(input logic [7:0] d);
    @(negedge CLK);
    RF_RdData = d; RF_RdData_VLD = 1;
    @(negedge CLK);
    RF_RdData_VLD = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr"}, RF_Address, 0);
    chk({tag, "_wren"}, RF_WrEn, 0);
    chk({tag, "_rden"}, RF_RdEn, 0);
    chk({tag, "_wdata"}, RF_WrData, 0);
    chk({tag, "_tdata"}, TX_P_DATA, 0);
    chk({tag, "_txvld"}, TX_D_VLD, 0);
    chk({tag, "_err"}, CMD_ERR, 0);
  endtask

  int wr0, rd0, tx0, er0;

  initial begin
    RST = 1; RX_P_DATA = 0; RX_D_VLD = 0; PAR_ERR = 0; STP_ERR = 0;
    RF_RdData = 0; RF_RdData_VLD = 0; FIFO_FULL = 0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(negedge CLK);
    RST = 0;

    // Basic write AA,05,3C
    wr0 = n_wr; er0 = n_err;
    send(8'hAA, 0, 0); send(8'h05, 0, 0); send(8'h3C, 0, 0);
    idle(3);
    chk("w1_count", n_wr - wr0, 1);
    chk("w1_addr", last_wr_addr, 4'h5);
    chk("w1_data", last_wr_data, 8'h3C);
    chk("w1_noerr", n_err - er0, 0);
    chk("w1_addr_hold", RF_Address, 4'h5);

    // Read BB,07 with response 3 cycles later
    rd0 = n_rd; tx0 = n_tx;
    send(8'hBB, 0, 0); send(8'h07, 0, 0);
    repeat (2) @(negedge CLK);
    rf_resp(8'h9E);
    idle(3);
    chk("r1_rd", n_rd - rd0, 1);
    chk("r1_addr", last_rd_addr, 4'h7);
    chk("r1_tx", n_tx - tx0, 1);
    chk("r1_txdata", last_tx, 8'h9E);

    // Read while the TX FIFO is full for 5 cycles
    tx0 = n_tx;
    FIFO_FULL = 1;
    send(8'hBB, 0, 0); send(8'h03, 0, 0);
    idle(2);
    rf_resp(8'h5A);
    idle(5);
    chk("full_nopush", n_tx - tx0, 0);
    FIFO_FULL = 0;
    idle(3);
    chk("full_push", n_tx - tx0, 1);
    chk("full_data", last_tx, 8'h5A);

    // Accepted byte during an outstanding read is dropped, read continues
    tx0 = n_tx; er0 = n_err;
    send(8'hBB, 0, 0); send(8'h0C, 0, 0);
    send(8'h77, 0, 0);
    rf_resp(8'h11);
    idle(3);
    chk("busy_err", n_err - er0, 1);
    chk("busy_tx", n_tx - tx0, 1);
    chk("busy_data", last_tx, 8'h11);

    // Corrupted byte during an outstanding read abandons it
    tx0 = n_tx; er0 = n_err;
    send(8'hBB, 0, 0); send(8'h0D, 0, 0);
    send(8'h44, 0, 1);
    rf_resp(8'h22);
    idle(4);
    chk("abandon_notx", n_tx - tx0, 0);
    chk("abandon_err", n_err - er0, 1);

    // Unknown command, then a normal write
    wr0 = n_wr; rd0 = n_rd; er0 = n_err;
    send(8'h12, 0, 0);
    idle(2);
    chk("unk_err", n_err - er0, 1);
    chk("unk_nowr", n_wr - wr0, 0);
    chk("unk_nord", n_rd - rd0, 0);
    send(8'hAA, 0, 0); send(8'h01, 0, 0); send(8'hFF, 0, 0);
    idle(3);
    chk("w2_count", n_wr - wr0, 1);
    chk("w2_addr", last_wr_addr, 4'h1);
    chk("w2_data", last_wr_data, 8'hFF);

    // Parity error mid-write returns to IDLE; 55 is then an unknown command
    wr0 = n_wr; er0 = n_err;
    send(8'hAA, 0, 0); send(8'h04, 1, 0);
    idle(2);
    chk("par_err", n_err - er0, 1);
    send(8'h55, 0, 0);
    idle(3);
    chk("par_then_unk", n_err - er0, 2);
    chk("par_nowr", n_wr - wr0, 0);
    chk("addr_hold", RF_Address, 4'h1);

    // Reset while waiting for the data byte
    wr0 = n_wr; er0 = n_err;
    send(8'hAA, 0, 0); send(8'h09, 0, 0);
    @(negedge CLK);
    #2 RST = 1;
    #1;
    chk_outputs_zero("midrst");
    @(negedge CLK);
    RST = 0;
    send(8'h3C, 0, 0);
    idle(3);
    chk("rst_nowr", n_wr - wr0, 0);
    chk("rst_err", n_err - er0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
